// File: rtl/timer_ctrl.sv
// Timer controller: owns TIMA/TMA/TAC, counts falling edges of a divider tap, sequences overflow/reload/IRQ.
// Latency: register writes land at the sampling edge; increment 1 cycle after tap fall; IRQ 1 cycle after TIMA=00.
// Backpressure: none; single-cycle bus strobes are always accepted. Option macro: TIMER_EDGE_GLITCH_EN.
module timer_ctrl #(
  parameter logic [7:0] TIMA_RST = 8'h00,
  parameter logic [7:0] TMA_RST  = 8'h00
) (
  input  logic       boga1mhz,
  input  logic       nreset2,
  input  logic       ff04_ff07,
  input  logic [1:0] a,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] wdata,
  input  logic [7:0] div_m,
  output logic [7:0] rdata,
  output logic       rdata_oe,
  output logic       div_clr,
  output logic       int_timer
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_OVF    = 2'd1;
  localparam logic [1:0] S_RELOAD = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_tima;
  logic [7:0] r_tma;
  logic [2:0] r_tac;
  logic       r_prev;

  logic       w_wr_tima;
  logic       w_wr_tma;
  logic       w_wr_tac;
  logic       w_tap;
  logic       w_prev_nxt;
  logic       w_inc;
  logic [7:0] w_tma_nxt;
  logic       w_unused;

  // Divider tap picked by a TAC clock-select field
  function automatic logic tap_sel(input logic [1:0] sel, input logic [7:0] dm);
    case (sel)
      2'b00:   tap_sel = dm[7];
      2'b01:   tap_sel = dm[1];
      2'b10:   tap_sel = dm[3];
      default: tap_sel = dm[5];
    endcase
  endfunction

  assign w_wr_tima = ff04_ff07 & cpu_wr & (a == 2'd1);
  assign w_wr_tma  = ff04_ff07 & cpu_wr & (a == 2'd2);
  assign w_wr_tac  = ff04_ff07 & cpu_wr & (a == 2'd3);
  assign div_clr   = ff04_ff07 & cpu_wr & (a == 2'd0);
  assign w_tap     = tap_sel(r_tac[1:0], div_m);
  // A TMA write in the same cycle as a reload is forwarded straight into TIMA
  assign w_tma_nxt = w_wr_tma ? wdata : r_tma;
  assign int_timer = (r_state == S_RELOAD);
  assign w_unused  = ^{div_m[6], div_m[4], div_m[2], div_m[0]};

`ifdef TIMER_EDGE_GLITCH_EN
  // Edge detect on the gated tap: disabling or re-selecting TAC can create a falling edge
  assign w_prev_nxt = r_tac[2] & w_tap;
  assign w_inc      = r_prev & ~(r_tac[2] & w_tap);
`else
  // Edge detect on the raw tap; a TAC write re-seeds prev from the new tap so it never glitches
  assign w_prev_nxt = w_wr_tac ? tap_sel(wdata[1:0], div_m) : w_tap;
  assign w_inc      = r_tac[2] & r_prev & ~w_tap;
`endif

  // Bus read mux; DIV (a=0) is driven by the divider block, not here
  always_comb begin
    rdata_oe = ff04_ff07 & cpu_rd & (a != 2'd0);
    rdata    = 8'h00;
    if (rdata_oe) begin
      case (a)
        2'd1:    rdata = r_tima;
        2'd2:    rdata = r_tma;
        default: rdata = {5'b11111, r_tac};
      endcase
    end
  end

  // TMA and TAC register writes
  always_ff @(posedge boga1mhz or negedge nreset2) begin
    if (!nreset2) begin
      r_tma <= TMA_RST;
      r_tac <= 3'b000;
    end else begin
      if (w_wr_tma) r_tma <= wdata;
      if (w_wr_tac) r_tac <= wdata[2:0];
    end
  end

  // Previous-cycle tap sample for falling-edge detection
  always_ff @(posedge boga1mhz or negedge nreset2) begin
    if (!nreset2) r_prev <= 1'b0;
    else          r_prev <= w_prev_nxt;
  end

  // TIMA counter with overflow -> reload sequencing; increments outside RUN are dropped
  always_ff @(posedge boga1mhz or negedge nreset2) begin
    if (!nreset2) begin
      r_state <= S_RUN;
      r_tima  <= TIMA_RST;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_wr_tima) begin
            r_tima <= wdata;
          end else if (w_inc) begin
            if (r_tima == 8'hFF) begin
              r_tima  <= 8'h00;
              r_state <= S_OVF;
            end else begin
              r_tima <= r_tima + 8'd1;
            end
          end
        end
        S_OVF: begin
          if (w_wr_tima) begin
            r_tima  <= wdata;
            r_state <= S_RUN;
          end else begin
            r_tima  <= w_tma_nxt;
            r_state <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          r_tima  <= w_tma_nxt;
          r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: vector table for bus/reset/overflow behaviour,
// then hand sequences for counting period, OVF/RELOAD writes, DIV clear, TAC glitch, reset abort.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       nreset2;
  logic       ff04_ff07;
  logic [1:0] a;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] wdata;
  logic [7:0] div_m;
  logic [7:0] rdata;
  logic       rdata_oe;
  logic       div_clr;
  logic       int_timer;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] dm;
    logic [7:0] e_rdata;
    logic       e_oe;
    logic       e_clr;
    logic       e_int;
  } vec_t;

  vec_t vecs[$];

  timer_ctrl dut (
    .boga1mhz (clk),
    .nreset2  (nreset2),
    .ff04_ff07(ff04_ff07),
    .a        (a),
    .cpu_wr   (cpu_wr),
    .cpu_rd   (cpu_rd),
    .wdata    (wdata),
    .div_m    (div_m),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .div_clr  (div_clr),
    .int_timer(int_timer)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h required %02h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b required %0b", nm, got, exp);
    end
  endtask

  // One bus cycle: inputs change just after the rising edge, outputs sampled at the falling edge
  task automatic cyc(input logic wr, input logic rd, input logic [1:0] aa,
                     input logic [7:0] wd, input logic [7:0] dm);
    @(posedge clk);
    #1;
    cpu_wr    = wr;
    cpu_rd    = rd;
    ff04_ff07 = wr | rd;
    a         = aa;
    wdata     = wd;
    div_m     = dm;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] aa, input logic [7:0] dm,
                        input logic [7:0] exp, input logic exp_int);
    cyc(1'b0, 1'b1, aa, 8'h00, dm);
    chk(nm, rdata, exp);
    chk1({nm, " int"}, int_timer, exp_int);
  endtask

  task automatic addv(input logic wr, input logic rd, input logic [1:0] aa, input logic [7:0] wd,
                      input logic [7:0] dm, input logic [7:0] er, input logic eo,
                      input logic ec, input logic ei);
    vec_t v;
    v.wr = wr; v.rd = rd; v.a = aa; v.wd = wd; v.dm = dm;
    v.e_rdata = er; v.e_oe = eo; v.e_clr = ec; v.e_int = ei;
    vecs.push_back(v);
  endtask

  // div_m 0..4 with TAC=5: the tap falls at 3->4 so an FF TIMA overflows at the edge ending dm=4
  task automatic run_to_ovf();
    for (int c = 0; c <= 4; c++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 8'(c));
  endtask

  initial begin
    logic [7:0] exp_glitch;
`ifdef TIMER_EDGE_GLITCH_EN
    exp_glitch = 8'h12;
`else
    exp_glitch = 8'h11;
`endif
    nreset2 = 1'b0; ff04_ff07 = 1'b0; a = 2'd0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    wdata = 8'h00; div_m = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst int", int_timer, 1'b0);
    chk1("rst oe", rdata_oe, 1'b0);
    chk1("rst clr", div_clr, 1'b0);
    nreset2 = 1'b1;

    // wr rd a wdata dm | rdata oe clr int
    addv(0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0); // TIMA reset value
    addv(0, 1, 2, 8'h00, 8'h00, 8'h00, 1, 0, 0); // TMA reset value
    addv(0, 1, 3, 8'h00, 8'h00, 8'hF8, 1, 0, 0); // TAC reset, upper bits read 1
    addv(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0); // DIV not driven here
    addv(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0); // FF04 write -> div_clr
    addv(1, 0, 3, 8'h06, 8'h00, 8'h00, 0, 0, 0); // TAC=6
    addv(0, 1, 3, 8'h00, 8'h00, 8'hFE, 1, 0, 0); // reads FE
    addv(1, 0, 3, 8'h05, 8'h00, 8'h00, 0, 0, 0); // TAC=5
    addv(1, 0, 2, 8'hA0, 8'h00, 8'h00, 0, 0, 0); // TMA=A0
    addv(1, 0, 1, 8'hFE, 8'h00, 8'h00, 0, 0, 0); // TIMA=FE
    addv(0, 1, 1, 8'h00, 8'h00, 8'hFE, 1, 0, 0);
    for (int c = 0; c <= 11; c++) begin
      logic [7:0] et;
      et = (c <= 4) ? 8'hFE : (c <= 8) ? 8'hFF : (c == 9) ? 8'h00 : 8'hA0;
      addv(0, 1, 1, 8'h00, 8'(c), et, 1, 0, (c == 10));
    end

    foreach (vecs[i]) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].dm);
      if (vecs[i].e_oe) chk($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rdata);
      chk1($sformatf("vec%0d oe", i), rdata_oe, vecs[i].e_oe);
      chk1($sformatf("vec%0d clr", i), div_clr, vecs[i].e_clr);
      chk1($sformatf("vec%0d int", i), int_timer, vecs[i].e_int);
    end

    // Period: TAC=5, counting div_m 0..16 gives four increments
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd1, 8'h00, 8'h00);
    cyc(1, 0, 2'd2, 8'h00, 8'h00);
    cyc(1, 0, 2'd3, 8'h05, 8'h00);
    for (int c = 0; c <= 16; c++) begin
      cyc(0, 1, 2'd1, 8'h00, 8'(c));
      if (c == 4) chk("period pre-inc", rdata, 8'h00);
      if (c == 5) chk("period 1st inc", rdata, 8'h01);
    end
    rd_chk("period 16 cycles", 2'd1, 8'd17, 8'h04, 1'b0);

    // TIMA write in OVF cancels reload and interrupt
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd1, 8'hFF, 8'h00);
    run_to_ovf();
    cyc(1, 0, 2'd1, 8'h33, 8'd5);
    chk1("ovf-wr int", int_timer, 1'b0);
    rd_chk("ovf-wr tima c6", 2'd1, 8'd6, 8'h33, 1'b0);
    rd_chk("ovf-wr tima c7", 2'd1, 8'd7, 8'h33, 1'b0);
    rd_chk("ovf-wr tima c8", 2'd1, 8'd8, 8'h33, 1'b0);
    rd_chk("ovf-wr resumes", 2'd1, 8'd9, 8'h34, 1'b0);

    // TMA write in RELOAD is loaded into TIMA
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd2, 8'h20, 8'h00);
    cyc(1, 0, 2'd1, 8'hFF, 8'h00);
    run_to_ovf();
    rd_chk("rl-tma ovf tima", 2'd1, 8'd5, 8'h00, 1'b0);
    cyc(1, 0, 2'd2, 8'h77, 8'd6);
    chk1("rl-tma int", int_timer, 1'b1);
    rd_chk("rl-tma tima", 2'd1, 8'd7, 8'h77, 1'b0);
    rd_chk("rl-tma tma", 2'd2, 8'd8, 8'h77, 1'b0);

    // TIMA write in RELOAD is ignored
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd1, 8'hFF, 8'h00);
    run_to_ovf();
    rd_chk("rl-tima ovf tima", 2'd1, 8'd5, 8'h00, 1'b0);
    cyc(1, 0, 2'd1, 8'h11, 8'd6);
    chk1("rl-tima int", int_timer, 1'b1);
    rd_chk("rl-tima tima", 2'd1, 8'd7, 8'h77, 1'b0);

    // DIV clear while tap (div_m[7]) is 1 increments TIMA one cycle later
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd1, 8'h10, 8'h00);
    cyc(1, 0, 2'd3, 8'h04, 8'h80);
    cyc(0, 0, 2'd0, 8'h00, 8'h80);
    cyc(1, 0, 2'd0, 8'h00, 8'h80);
    chk1("divclr strobe", div_clr, 1'b1);
    rd_chk("divclr latency", 2'd1, 8'h00, 8'h10, 1'b0);
    chk1("divclr released", div_clr, 1'b0);
    rd_chk("divclr inc", 2'd1, 8'h00, 8'h11, 1'b0);

    // Disabling TAC while tap is 1
    cyc(1, 0, 2'd3, 8'h04, 8'h80);
    cyc(0, 0, 2'd0, 8'h00, 8'h80);
    cyc(1, 0, 2'd3, 8'h00, 8'h80);
    rd_chk("tac-off before", 2'd1, 8'h80, 8'h11, 1'b0);
    rd_chk("tac-off glitch", 2'd1, 8'h80, exp_glitch, 1'b0);

    // Reset asserted in RELOAD aborts the interrupt and restores all registers
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    cyc(1, 0, 2'd1, 8'hFF, 8'h00);
    cyc(1, 0, 2'd3, 8'h05, 8'h00);
    run_to_ovf();
    rd_chk("rst-rl ovf", 2'd1, 8'd5, 8'h00, 1'b0);
    rd_chk("rst-rl reload", 2'd1, 8'd6, 8'h77, 1'b1);
    nreset2 = 1'b0;
    #1;
    chk1("rst-rl int", int_timer, 1'b0);
    cyc(0, 0, 2'd0, 8'h00, 8'h00);
    chk1("rst-rl held int", int_timer, 1'b0);
    nreset2 = 1'b1;
    rd_chk("rst-rl tima", 2'd1, 8'h00, 8'h00, 1'b0);
    rd_chk("rst-rl tma", 2'd2, 8'h00, 8'h00, 1'b0);
    rd_chk("rst-rl tac", 2'd3, 8'h00, 8'hF8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
